// File: rtl/vram_console_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_console_ctrl: text console engine (putc/clear/scroll/setcur) that    |
// | shares VRAM port A with a CPU that always wins arbitration.              |
// | Option macro: VRAM_CONSOLE_AUTOSCROLL_EN (scroll on row overflow).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vram_console_ctrl #(
   parameter int         COLS      = 80,
   parameter int         ROWS      = 50,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_OP,
   input  logic [15:0] CMD_DATA,
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [11:0] CPU_ADDR,
   input  logic [15:0] CPU_WDATA,
   output logic        CPU_GNT,
   output logic [15:0] CPU_RDATA,
   output logic        VRAM_WE,
   output logic [11:0] VRAM_ADDR,
   output logic [15:0] VRAM_WDATA,
   input  logic [15:0] VRAM_RDATA,
   output logic        BUSY,
   output logic [6:0]  CUR_X,
   output logic [5:0]  CUR_Y
);

`ifdef VRAM_CONSOLE_AUTOSCROLL_EN
   localparam logic c_AUTOSCROLL = 1'b1;
`else
   localparam logic c_AUTOSCROLL = 1'b0;
`endif

   localparam logic [11:0] c_COLS12   = 12'(COLS);
   localparam logic [11:0] c_LAST     = 12'(COLS * ROWS - 1);
   localparam logic [11:0] c_SCR_LAST = 12'((ROWS - 1) * COLS - 1);
   localparam logic [6:0]  c_X_MAX    = 7'(COLS - 1);
   localparam logic [5:0]  c_Y_MAX    = 6'(ROWS - 1);

   localparam logic [1:0] c_OP_PUTC   = 2'b00;
   localparam logic [1:0] c_OP_CLEAR  = 2'b01;
   localparam logic [1:0] c_OP_SCROLL = 2'b10;
   localparam logic [1:0] c_OP_SETCUR = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PUT      = 3'd1,
      CLR      = 3'd2,
      SCR_RD   = 3'd3,
      SCR_WR   = 3'd4,
      SCR_FILL = 3'd5
   } state_t;

   state_t      r_state;
   logic [6:0]  r_cur_x;
   logic [5:0]  r_cur_y;
   logic [7:0]  r_fill_attr;
   logic [15:0] r_hold;
   logic        r_rd_pend;
   logic [11:0] r_addr;
   logic [15:0] r_put_data;

   logic        w_eng_we;
   logic [11:0] w_eng_addr;
   logic [15:0] w_eng_wdata;
   logic [11:0] w_cell;
   logic        w_y_ovf;
   logic        w_row_scroll;
   logic [5:0]  w_y_next;
   logic [6:0]  w_set_x;
   logic [5:0]  w_set_y;
   logic [7:0]  w_char;

   // Constant-coefficient multiply: y*COLS as a sum of shifted copies of y.
   function automatic logic [11:0] f_cell(input logic [6:0] x, input logic [5:0] y);
      logic [11:0] w_sum;
      w_sum = {5'd0, x};
      for (int i = 0; i < 12; i++) begin
         if (c_COLS12[i]) w_sum = w_sum + ({6'd0, y} << i);
      end
      return w_sum;
   endfunction

   assign w_cell       = f_cell(r_cur_x, r_cur_y);
   assign w_y_ovf      = (r_cur_y == c_Y_MAX);
   assign w_row_scroll = w_y_ovf && c_AUTOSCROLL;
   assign w_y_next     = w_y_ovf ? (c_AUTOSCROLL ? c_Y_MAX : 6'd0) : r_cur_y + 6'd1;
   assign w_set_x      = (CMD_DATA[6:0] > c_X_MAX) ? c_X_MAX : CMD_DATA[6:0];
   assign w_set_y      = (CMD_DATA[13:8] > c_Y_MAX) ? c_Y_MAX : CMD_DATA[13:8];
   assign w_char       = CMD_DATA[7:0];

   // The SCR_WR right after an uncontended read forwards the live read data.
   always_comb begin
      w_eng_we    = 1'b0;
      w_eng_addr  = r_addr;
      w_eng_wdata = {r_fill_attr, FILL_CHAR};
      case (r_state)
         PUT: begin
            w_eng_we    = 1'b1;
            w_eng_wdata = r_put_data;
         end
         CLR, SCR_FILL: w_eng_we = 1'b1;
         SCR_RD:        w_eng_addr = r_addr + c_COLS12;
         SCR_WR: begin
            w_eng_we    = 1'b1;
            w_eng_wdata = r_rd_pend ? VRAM_RDATA : r_hold;
         end
         default: ;
      endcase
   end

   assign CPU_GNT    = CPU_REQ;
   assign CPU_RDATA  = VRAM_RDATA;
   assign VRAM_WE    = CPU_REQ ? CPU_WE    : w_eng_we;
   assign VRAM_ADDR  = CPU_REQ ? CPU_ADDR  : w_eng_addr;
   assign VRAM_WDATA = CPU_REQ ? CPU_WDATA : w_eng_wdata;
   assign CMD_READY  = (r_state == IDLE) && !CPU_REQ;
   assign BUSY       = (r_state != IDLE);
   assign CUR_X      = r_cur_x;
   assign CUR_Y      = r_cur_y;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_cur_x     <= 7'd0;
         r_cur_y     <= 6'd0;
         r_fill_attr <= 8'h07;
         r_hold      <= 16'h0000;
         r_rd_pend   <= 1'b0;
         r_addr      <= 12'd0;
         r_put_data  <= 16'h0000;
      end else begin
         // Read capture runs even while the CPU owns the port.
         r_rd_pend <= (r_state == SCR_RD) && !CPU_REQ;
         if (r_rd_pend) r_hold <= VRAM_RDATA;

         if (!CPU_REQ) begin
            case (r_state)
               IDLE: begin
                  if (CMD_VALID) begin
                     case (CMD_OP)
                        c_OP_PUTC: begin
                           r_fill_attr <= CMD_DATA[15:8];
                           if (w_char == 8'h0D) begin
                              r_cur_x <= 7'd0;
                           end else if (w_char == 8'h0A) begin
                              r_cur_x <= 7'd0;
                              r_cur_y <= w_y_next;
                              if (w_row_scroll) begin
                                 r_addr  <= 12'd0;
                                 r_state <= SCR_RD;
                              end
                           end else begin
                              r_put_data <= CMD_DATA;
                              r_addr     <= w_cell;
                              r_state    <= PUT;
                           end
                        end
                        c_OP_CLEAR: begin
                           r_fill_attr <= CMD_DATA[15:8];
                           r_addr      <= 12'd0;
                           r_state     <= CLR;
                        end
                        c_OP_SCROLL: begin
                           r_fill_attr <= CMD_DATA[15:8];
                           r_addr      <= 12'd0;
                           r_state     <= SCR_RD;
                        end
                        c_OP_SETCUR: begin
                           r_cur_x <= w_set_x;
                           r_cur_y <= w_set_y;
                        end
                        default: ;
                     endcase
                  end
               end
               PUT: begin
                  r_state <= IDLE;
                  if (r_cur_x == c_X_MAX) begin
                     r_cur_x <= 7'd0;
                     r_cur_y <= w_y_next;
                     if (w_row_scroll) begin
                        r_addr  <= 12'd0;
                        r_state <= SCR_RD;
                     end
                  end else begin
                     r_cur_x <= r_cur_x + 7'd1;
                  end
               end
               CLR: begin
                  if (r_addr == c_LAST) begin
                     r_state <= IDLE;
                     r_cur_x <= 7'd0;
                     r_cur_y <= 6'd0;
                  end else begin
                     r_addr <= r_addr + 12'd1;
                  end
               end
               SCR_RD: r_state <= SCR_WR;
               SCR_WR: begin
                  r_addr  <= r_addr + 12'd1;
                  r_state <= (r_addr == c_SCR_LAST) ? SCR_FILL : SCR_RD;
               end
               SCR_FILL: begin
                  if (r_addr == c_LAST) r_state <= IDLE;
                  else                  r_addr  <= r_addr + 12'd1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vram_console_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vram_console_ctrl: scoreboard bench for vram_console_ctrl.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vram_console_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CMD_VALID, CMD_READY;
   logic [1:0]  CMD_OP;
   logic [15:0] CMD_DATA;
   logic        CPU_REQ, CPU_WE, CPU_GNT;
   logic [11:0] CPU_ADDR;
   logic [15:0] CPU_WDATA, CPU_RDATA;
   logic        VRAM_WE;
   logic [11:0] VRAM_ADDR;
   logic [15:0] VRAM_WDATA;
   logic [15:0] VRAM_RDATA = 16'h0000;
   logic        BUSY;
   logic [6:0]  CUR_X;
   logic [5:0]  CUR_Y;

   vram_console_ctrl dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_GNT(CPU_GNT), .CPU_RDATA(CPU_RDATA),
      .VRAM_WE(VRAM_WE), .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA), .VRAM_RDATA(VRAM_RDATA),
      .BUSY(BUSY), .CUR_X(CUR_X), .CUR_Y(CUR_Y)
   );

   always #5 CLK = ~CLK;

   // Single-port VRAM, one-cycle read latency.
   logic [15:0] mem [0:4095];
   always @(posedge CLK) begin
      if (VRAM_WE) mem[VRAM_ADDR] <= VRAM_WDATA;
      VRAM_RDATA <= mem[VRAM_ADDR];
   end

   int          errors = 0;
   int          checks = 0;
   logic [15:0] model     [0:3999];
   logic [15:0] ref_mem   [0:3999];
   logic [15:0] cpu_model [0:95];
   logic [31:0] q [$];
   logic [31:0] mon_exp;
   logic        mon_en   = 1'b0;
   logic        scr_done = 1'b0;
   int          cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Engine writes only; CPU-granted cycles are not engine traffic.
   always @(negedge CLK) begin
      if (mon_en && VRAM_WE && !CPU_GNT) begin
         mon_exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
         check("eng_wr", {4'h0, VRAM_ADDR, VRAM_WDATA}, mon_exp);
      end
   end

   task automatic exp_wr(input int a, input logic [15:0] d);
      q.push_back({4'h0, 12'(a), d});
      model[a] = d;
   endtask

   task automatic push_scroll(input logic [7:0] attr);
      for (int a = 0; a < 3920; a++) exp_wr(a, model[a + 80]);
      for (int a = 3920; a < 4000; a++) exp_wr(a, {attr, 8'h20});
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] d);
      int n;
      n = 0;
      @(posedge CLK); #1;
      CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = d;
      forever begin
         @(negedge CLK);
         if (CMD_READY) begin
            @(posedge CLK);
            break;
         end
         n++;
         if (n > 30000) begin
            check("cmd_accept", CMD_READY, 1);
            break;
         end
         @(posedge CLK);
      end
      #1 CMD_VALID = 1'b0;
   endtask

   task automatic setcur(input int x, input int y);
      send_cmd(2'b11, {2'b00, 6'(y), 1'b0, 7'(x)});
   endtask

   task automatic wait_idle(output int c);
      c = 0;
      forever begin
         @(negedge CLK);
         if (!BUSY) break;
         c++;
         if (c > 30000) begin
            check("busy_timeout", BUSY, 0);
            break;
         end
      end
   endtask

   task automatic preload();
      for (int a = 0; a < 4000; a++) begin
         @(posedge CLK); #1;
         CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 12'(a);
         CPU_WDATA = (a >= 80 && a < 160) ? 16'h0100 + 16'(a - 80) : 16'h8000 | 16'(a);
         model[a] = CPU_WDATA;
      end
      @(posedge CLK); #1;
      CPU_REQ = 1'b0; CPU_WE = 1'b0;
   endtask

   task automatic mem_cmp(input string tag);
      int bad;
      bad = 0;
      for (int a = 0; a < 4000; a++) if (mem[a] !== model[a]) bad++;
      check(tag, bad, 0);
   endtask

   // CPU owns the port one cycle in three: alternate write / read-back above the screen.
   task automatic cpu_pulses();
      int k, idx;
      k = 0;
      while (!scr_done) begin
         idx = (k / 2) % 96;
         @(posedge CLK); #1;
         CPU_REQ = 1'b1; CPU_WE = (k % 2 == 0); CPU_ADDR = 12'(4000 + idx);
         CPU_WDATA = 16'hC000 + 16'(k);
         if (k % 2 == 0) cpu_model[idx] = CPU_WDATA;
         @(negedge CLK);
         check("cpu_gnt", CPU_GNT, 1);
         @(posedge CLK); #1;
         CPU_REQ = 1'b0; CPU_WE = 1'b0;
         if (k % 2 == 1) begin
            @(negedge CLK);
            check("cpu_rd", CPU_RDATA, cpu_model[idx]);
         end
         @(posedge CLK);
         k++;
      end
   endtask

   initial begin
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_DATA = 16'h0000;
      CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = 12'd0; CPU_WDATA = 16'h0000;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      mon_en = 1'b1;
      @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_ready", CMD_READY, 1);
      check("rst_we", VRAM_WE, 0);
      check("rst_x", CUR_X, 0);
      check("rst_y", CUR_Y, 0);

      exp_wr(0, 16'h1E41);
      send_cmd(2'b00, 16'h1E41);
      @(negedge CLK);
      check("putc_we", VRAM_WE, 1);
      check("putc_addr", VRAM_ADDR, 0);
      check("putc_data", VRAM_WDATA, 16'h1E41);
      @(negedge CLK);
      check("putc_x", CUR_X, 1);
      check("putc_idle", BUSY, 0);

      setcur(100, 60);
      @(negedge CLK);
      check("clamp_x", CUR_X, 79);
      check("clamp_y", CUR_Y, 49);

      setcur(79, 2);
      exp_wr(239, 16'h0742);
      send_cmd(2'b00, 16'h0742);
      @(negedge CLK);
      check("wrap_addr", VRAM_ADDR, 239);
      @(negedge CLK);
      check("wrap_x", CUR_X, 0);
      check("wrap_y", CUR_Y, 3);

      setcur(10, 4);
      send_cmd(2'b00, 16'h070D);
      @(negedge CLK);
      check("cr_ready", CMD_READY, 1);
      check("cr_x", CUR_X, 0);
      check("cr_y", CUR_Y, 4);
      setcur(10, 4);
      send_cmd(2'b00, 16'h070A);
      @(negedge CLK);
      check("lf_x", CUR_X, 0);
      check("lf_y", CUR_Y, 5);

      setcur(3, 3);
      for (int a = 0; a < 4000; a++) exp_wr(a, 16'h1F20);
      send_cmd(2'b01, 16'h1F00);
      wait_idle(cyc);
      check("clr_cycles", cyc, 4000);
      check("clr_x", CUR_X, 0);
      check("clr_y", CUR_Y, 0);
      check("clr_drain", q.size(), 0);
      mem_cmp("clr_mem");

      preload();
      setcur(7, 9);
      push_scroll(8'h07);
      send_cmd(2'b10, 16'h0700);
      wait_idle(cyc);
      check("scr_cycles", cyc, 7920);
      check("scr_x", CUR_X, 7);
      check("scr_y", CUR_Y, 9);
      check("scr_drain", q.size(), 0);
      begin
         int bad0, bad49;
         bad0 = 0; bad49 = 0;
         for (int c = 0; c < 80; c++) begin
            if (mem[c] !== 16'h0100 + 16'(c)) bad0++;
            if (mem[3920 + c] !== 16'h0720) bad49++;
         end
         check("scr_row0", bad0, 0);
         check("scr_row49", bad49, 0);
      end
      mem_cmp("scr_mem");
      for (int a = 0; a < 4000; a++) ref_mem[a] = model[a];

      preload();
      push_scroll(8'h07);
      scr_done = 1'b0;
      fork
         begin
            send_cmd(2'b10, 16'h0700);
            wait_idle(cyc);
            scr_done = 1'b1;
         end
         cpu_pulses();
      join
      check("cont_drain", q.size(), 0);
      begin
         int bad;
         bad = 0;
         for (int a = 0; a < 4000; a++) if (mem[a] !== ref_mem[a]) bad++;
         check("cont_mem", bad, 0);
      end

      setcur(79, 49);
      exp_wr(3999, 16'h2E43);
`ifdef VRAM_CONSOLE_AUTOSCROLL_EN
      push_scroll(8'h2E);
`endif
      send_cmd(2'b00, 16'h2E43);
      wait_idle(cyc);
`ifdef VRAM_CONSOLE_AUTOSCROLL_EN
      check("auto_cycles", cyc, 7921);
      check("auto_x", CUR_X, 0);
      check("auto_y", CUR_Y, 49);
`else
      check("auto_cycles", cyc, 1);
      check("auto_x", CUR_X, 0);
      check("auto_y", CUR_Y, 0);
`endif
      check("auto_drain", q.size(), 0);
      mem_cmp("auto_mem");

      setcur(5, 5);
      for (int a = 0; a < 4000; a++) exp_wr(a, 16'h3120);
      send_cmd(2'b01, 16'h3100);
      repeat (100) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      q.delete();
      check("abort_busy", BUSY, 0);
      check("abort_we", VRAM_WE, 0);
      check("abort_x", CUR_X, 0);
      check("abort_y", CUR_Y, 0);
      check("abort_ready", CMD_READY, 1);
      repeat (3) @(negedge CLK);
      check("abort_stay", BUSY, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/vram_console_ctrl.md
VRAM_CONSOLE_CTRL -- requirements
Module: vram_console_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- COLS, 80, characters per row.
- ROWS, 50, character rows.
- FILL_CHAR, 8'h20, character code written by clear and scroll.
REQ-002 SHALL have ports, one per line:
- CLK  in  1  system clock; VRAM port A clock.
- RST  in  1  reset: synchronous, active-high.
- CMD_VALID  in  1  command strobe.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_OP  in  2  00 PUTC, 01 CLEAR, 10 SCROLL, 11 SETCUR.
- CMD_DATA  in  16  PUTC: {attr,char}; CLEAR/SCROLL: [15:8] fill attr; SETCUR: [13:8] y, [6:0] x.
- CPU_REQ  in  1  direct CPU VRAM access request.
- CPU_WE  in  1  CPU write enable.
- CPU_ADDR  in  12  CPU word address.
- CPU_WDATA  in  16  CPU write data.
- CPU_GNT  out  1  CPU owns port this cycle.
- CPU_RDATA  out  16  CPU read data, valid the cycle after grant.
- VRAM_WE  out  1  port A write enable.
- VRAM_ADDR  out  12  port A address.
- VRAM_WDATA  out  16  port A write data.
- VRAM_RDATA  in  16  port A read data, one-cycle latency.
- BUSY  out  1  engine not idle.
- CUR_X  out  7  cursor column.
- CUR_Y  out  6  cursor row.

Function
REQ-003 SHALL implement states IDLE, PUT, CLR, SCR_RD, SCR_WR, SCR_FILL.
REQ-004 SHALL grant CPU_GNT=CPU_REQ combinationally; CPU has absolute priority; VRAM_* driven from CPU_* when granted.
REQ-005 SHALL drive CPU_RDATA=VRAM_RDATA.
REQ-006 SHALL freeze engine state, counters and cursor in any cycle CPU_GNT=1; no engine access is lost or duplicated.
REQ-007 SHALL assert CMD_READY only in IDLE with CPU_REQ=0; BUSY=(state!=IDLE).
REQ-008 SHALL compute cell address as CUR_Y*COLS+CUR_X, 12-bit, using shifts/adds only.
REQ-009 PUTC printable (char not 0x0A/0x0D): accept cycle N -> VRAM_WE=1, write {attr,char} at cursor cycle N+1 (uncontended) -> IDLE at N+2; CUR_X+1; CUR_X==COLS-1 -> CUR_X=0, CUR_Y+1.
REQ-010 PUTC 0x0D: CUR_X=0, no VRAM write, READY stays high.
REQ-011 PUTC 0x0A: CUR_X=0, CUR_Y+1, no VRAM write.
REQ-012 SHALL latch the PUTC attribute as the fill attribute for automatic scroll.
REQ-013 CLEAR: write {attr,FILL_CHAR} to addresses 0..COLS*ROWS-1, one per uncontended cycle; cursor <= (0,0) on completion.
REQ-014 SCROLL: for a=0..(ROWS-1)*COLS-1, SCR_RD reads a+COLS, SCR_WR writes captured data to a; then SCR_FILL writes {attr,FILL_CHAR} to the last row; cursor unchanged.
REQ-015 SHALL capture VRAM_RDATA into a hold register exactly in the cycle after an engine read, including when CPU holds the port that cycle; SCR_WR waits for the port without re-reading.
REQ-016 SETCUR: load x,y; x>COLS-1 clamps to COLS-1, y>ROWS-1 clamps to ROWS-1; no VRAM access.
REQ-017 CUR_Y incrementing past ROWS-1 SHALL follow the configuration in REQ-021/REQ-022.
REQ-018 SHALL ignore CMD_* while CMD_READY=0.

Reset
REQ-019 RST SHALL force state IDLE, CUR_X=0, CUR_Y=0, fill attr=8'h07, hold register 0, VRAM_WE=0 (when CPU_REQ=0), BUSY=0, CMD_READY=1 (if CPU_REQ=0).
REQ-020 RST during CLR/SCROLL SHALL abort immediately; partially updated VRAM is left as is.

Configuration
REQ-021 With VRAM_CONSOLE_AUTOSCROLL_EN defined: row overflow sets CUR_Y=ROWS-1 and runs a full SCROLL with the latched attribute before returning IDLE.
REQ-022 Without VRAM_CONSOLE_AUTOSCROLL_EN: row overflow wraps CUR_Y to 0, no scroll; explicit SCROLL command still supported.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Reset, PUTC 16'h1E41 -> one write addr 0 data 16'h1E41 one cycle after accept, CUR_X=1.
- SETCUR x=79 y=2, PUTC 'B' -> write addr 239; cursor (0,3).
- Row 1 preloaded with 0x0100+col, SCROLL attr 0x07 -> row 0 equals old row 1, row 49 all 16'h0720, 7840+80 uncontended engine cycles.
- CPU_REQ pulsed every third cycle during SCROLL -> CPU reads/writes correct, final VRAM identical to uncontended run.
- Cursor (79,49), PUTC with AUTOSCROLL_EN -> scroll performed, cursor (0,49); without -> no scroll, cursor (0,0).
- RST asserted mid-CLEAR -> next cycle IDLE, cursor (0,0), VRAM_WE=0.
